// File: rtl/switch_ctrl_pkg.sv
// switch_ctrl shared constants, port/FSM encodings and routing helpers.
// Optional perf counters are enabled with SWITCH_CTRL_PERF_CNT_EN.
package switch_ctrl_pkg;

    localparam int NPORT      = 5;
    localparam int TAM_FLIT   = 16;
    localparam int REG3       = 3;
    localparam int METADEFLIT = TAM_FLIT / 2;
    localparam int QUARTOFLIT = TAM_FLIT / 4;
    localparam int NP_REGF    = NPORT * TAM_FLIT;
    localparam int NP_REG3    = NPORT * REG3;
    localparam int CNT_W      = 16;

    typedef logic [REG3-1:0] port_t;

    localparam port_t EAST  = 3'd0;
    localparam port_t WEST  = 3'd1;
    localparam port_t NORTH = 3'd2;
    localparam port_t SOUTH = 3'd3;
    localparam port_t LOCAL = 3'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_ROUTE = 2'd2;
    localparam logic [1:0] S_GRANT = 2'd3;

    // Port index p advanced by k positions around the ring.
    function automatic port_t port_add(input port_t p, input int k);
        int s;
        s = (int'(p) + k) % NPORT;
        return port_t'(s);
    endfunction

    // Entry i of a packed per-port table.
    function automatic port_t port_at(input logic [NP_REG3-1:0] v,
                                      input int i);
        return v[i*REG3 +: REG3];
    endfunction

    // XY routing: resolve X first, then Y, LOCAL on exact match.
    function automatic port_t xy_route(input logic [TAM_FLIT-1:0] flit,
                                       input logic [METADEFLIT-1:0] addr);
        logic [QUARTOFLIT-1:0] tx, ty, lx, ly;
        port_t d;
        tx = flit[METADEFLIT-1:QUARTOFLIT];
        ty = flit[QUARTOFLIT-1:0];
        lx = addr[METADEFLIT-1:QUARTOFLIT];
        ly = addr[QUARTOFLIT-1:0];
        if (tx == lx && ty == ly)
            d = LOCAL;
        else if (lx < tx)
            d = EAST;
        else if (lx > tx)
            d = WEST;
        else if (ly < ty)
            d = NORTH;
        else
            d = SOUTH;
        return d;
    endfunction

endpackage

// File: rtl/switch_ctrl_if.sv
// Router-side bundle between input buffers, crossbar and switch_ctrl.
// grant_cnt/block_cnt exist only with SWITCH_CTRL_PERF_CNT_EN.
interface switch_ctrl_if;
    import switch_ctrl_pkg::*;

    logic [NPORT-1:0]      h;
    logic [NPORT-1:0]      sender;
    logic [NP_REGF-1:0]    data_t;
    logic [METADEFLIT-1:0] address;
    logic [NPORT-1:0]      ack_h;
    logic [NPORT-1:0]      free;
    logic [NP_REG3-1:0]    tab_in_t;
    logic [NP_REG3-1:0]    tab_out_t;
`ifdef SWITCH_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0]      grant_cnt;
    logic [CNT_W-1:0]      block_cnt;
`endif

    modport master (
        output h, sender, data_t, address,
`ifdef SWITCH_CTRL_PERF_CNT_EN
        input  grant_cnt, block_cnt,
`endif
        input  ack_h, free, tab_in_t, tab_out_t
    );

    modport slave (
        input  h, sender, data_t, address,
`ifdef SWITCH_CTRL_PERF_CNT_EN
        output grant_cnt, block_cnt,
`endif
        output ack_h, free, tab_in_t, tab_out_t
    );

endinterface

// File: rtl/switch_ctrl_rr_arbiter.sv
// Round-robin requester select; search begins one past i_prio.
// Purely combinational; the caller registers the result.
module rr_arbiter
    import switch_ctrl_pkg::*;
(
    input  logic [NPORT-1:0] i_req,
    input  port_t            i_prio,
    output port_t            o_idx,
    output logic             o_valid
);

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NPORT; k >= 1; k--) begin
            if (i_req[port_add(i_prio, k)]) begin
                o_valid = 1'b1;
                o_idx   = port_add(i_prio, k);
            end
        end
    end

endmodule

// File: rtl/switch_ctrl.sv
// Phoenix router switch control: RR arbitration, XY routing, crossbar tables.
// Define SWITCH_CTRL_PERF_CNT_EN to add grant/block counters.
module switch_ctrl
    import switch_ctrl_pkg::*;
(
    input  logic          i_clock,
    input  logic          i_reset,
    switch_ctrl_if.slave  io_sw
);

    logic [1:0]          r_state;
    port_t               r_prio;
    port_t               r_sel;
    logic [TAM_FLIT-1:0] r_flit;
    logic [NPORT-1:0]    r_free;
    logic [NPORT-1:0]    r_ack;
    logic [NP_REG3-1:0]  r_tab_in;
    logic [NP_REG3-1:0]  r_tab_out;

    port_t               w_arb_idx;
    logic                w_arb_valid;
    port_t               w_dir;
    logic                w_live;
    logic                w_grant;
    logic                w_block;
    logic [NPORT-1:0]    w_release;

    rr_arbiter u_arb (
        .i_req   (io_sw.h),
        .i_prio  (r_prio),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Route decision for the latched header against registered free.
    always_comb begin
        w_dir   = xy_route(r_flit, io_sw.address);
        w_live  = io_sw.h[r_sel];
        w_grant = (r_state == S_ROUTE) && w_live && r_free[w_dir];
        w_block = (r_state == S_ROUTE) && w_live && !r_free[w_dir];
    end

    // Owned output goes free once its input stops sending.
    always_comb begin
        w_release = '0;
        for (int o = 0; o < NPORT; o++) begin
            w_release[o] = !r_free[o] &&
                           !io_sw.sender[port_at(r_tab_out, o)];
        end
    end

    // Arbitration FSM: pick requester, latch header, resolve route.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_prio  <= LOCAL;
            r_sel   <= '0;
            r_flit  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|io_sw.h)
                        r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_arb_valid) begin
                        r_sel   <= w_arb_idx;
                        r_flit  <= io_sw.data_t[int'(w_arb_idx)*TAM_FLIT +: TAM_FLIT];
                        r_state <= S_ROUTE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ROUTE: begin
                    if (w_live) begin
                        r_prio  <= r_sel;
                        r_state <= w_grant ? S_GRANT : S_IDLE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Grant pulse, output reservation/release and crossbar tables.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_free    <= '1;
            r_ack     <= '0;
            r_tab_in  <= '0;
            r_tab_out <= '0;
        end else begin
            r_ack  <= '0;
            r_free <= r_free | w_release;
            if (w_grant) begin
                r_ack[r_sel]  <= 1'b1;
                r_free[w_dir] <= 1'b0;
                r_tab_out[int'(w_dir)*REG3 +: REG3] <= r_sel;
                r_tab_in[int'(r_sel)*REG3 +: REG3]  <= w_dir;
            end
        end
    end

    assign io_sw.ack_h     = r_ack;
    assign io_sw.free      = r_free;
    assign io_sw.tab_in_t  = r_tab_in;
    assign io_sw.tab_out_t = r_tab_out;

`ifdef SWITCH_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_grant_cnt;
    logic [CNT_W-1:0] r_block_cnt;

    // Free-running wrap counters of grants and blocked route attempts.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_grant_cnt <= '0;
            r_block_cnt <= '0;
        end else begin
            if (w_grant)
                r_grant_cnt <= r_grant_cnt + 1'b1;
            if (w_block)
                r_block_cnt <= r_block_cnt + 1'b1;
        end
    end

    assign io_sw.grant_cnt = r_grant_cnt;
    assign io_sw.block_cnt = r_block_cnt;
`endif

endmodule

// File: tb/tb_switch_ctrl.sv
// Self-checking bench for switch_ctrl: vector table plus scoreboard
// of expected grants; counter checks under SWITCH_CTRL_PERF_CNT_EN.
module tb_switch_ctrl;
    import switch_ctrl_pkg::*;

    typedef struct {
        port_t       src;
        logic [15:0] hdr;
        port_t       dir;
    } vec_t;

    typedef struct {
        port_t src;
        port_t dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    switch_ctrl_if bus();

    switch_ctrl dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_sw   (bus)
    );

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_hdr(input port_t p, input logic [15:0] f);
        bus.data_t[int'(p)*TAM_FLIT +: TAM_FLIT] = f;
    endtask

    task automatic wait_ack(input int lim, output logic got, output int n);
        got = 1'b0;
        n   = 0;
        while (!got && n < lim) begin
            cyc();
            n++;
            if (bus.ack_h != '0)
                got = 1'b1;
        end
    endtask

    // Compare the visible grant with the head of the scoreboard.
    task automatic check_grant(input string name, input int n,
                               input int exp_lat);
        exp_t e;
        logic [NPORT-1:0] m;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            m = '0;
            m[e.src] = 1'b1;
            check({name, "_ack"}, bus.ack_h, m);
            check({name, "_tab_in"}, port_at(bus.tab_in_t, e.src), e.dir);
            check({name, "_tab_out"}, port_at(bus.tab_out_t, e.dir), e.src);
            check({name, "_free"}, bus.free[e.dir], 0);
            if (exp_lat > 0)
                check({name, "_lat"}, n, exp_lat);
        end
    endtask

    task automatic do_req(input string name, input port_t src,
                          input logic [15:0] hdr, input port_t dir);
        logic got;
        int   n;
        set_hdr(src, hdr);
        bus.sender[src] = 1'b1;
        bus.h[src]      = 1'b1;
        sb.push_back('{src: src, dir: dir});
        wait_ack(20, got, n);
        bus.h[src] = 1'b0;
        if (!got) begin
            check({name, "_timeout"}, 1, 0);
            void'(sb.pop_front());
        end else begin
            check_grant(name, n, 3);
        end
        cyc();
        check({name, "_ack_drop"}, bus.ack_h, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic got;
        int   n;
        int   prev;
        logic saw;

        vecs[0] = '{src: WEST,  hdr: 16'h0011, dir: LOCAL};
        vecs[1] = '{src: LOCAL, hdr: 16'h0022, dir: EAST};
        vecs[2] = '{src: LOCAL, hdr: 16'h0012, dir: NORTH};
        vecs[3] = '{src: LOCAL, hdr: 16'h0010, dir: SOUTH};
        vecs[4] = '{src: NORTH, hdr: 16'h0001, dir: WEST};
        vecs[5] = '{src: SOUTH, hdr: 16'h0031, dir: EAST};
        vecs[6] = '{src: EAST,  hdr: 16'h0013, dir: NORTH};

        rst         = 1'b1;
        bus.h       = '0;
        bus.sender  = '0;
        bus.data_t  = '0;
        bus.address = 8'h11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_free", bus.free, 5'h1F);
        check("rst_ack", bus.ack_h, 0);
        check("rst_tab_in", bus.tab_in_t, 0);
        check("rst_tab_out", bus.tab_out_t, 0);
        cyc();

        // XY routing table, each output released afterwards.
        for (int i = 0; i < 7; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].src, vecs[i].hdr,
                   vecs[i].dir);
            bus.sender[vecs[i].src] = 1'b0;
            cyc();
            check($sformatf("vec%0d_release", i), bus.free, 5'h1F);
        end

        // Contention: EAST holds LOCAL, NORTH blocked until release.
        do_req("hold", EAST, 16'h0011, LOCAL);
        set_hdr(NORTH, 16'h0011);
        bus.sender[NORTH] = 1'b1;
        bus.h[NORTH]      = 1'b1;
        sb.push_back('{src: NORTH, dir: LOCAL});
        saw = 1'b0;
        repeat (12) begin
            cyc();
            if (bus.ack_h != '0)
                saw = 1'b1;
        end
        check("blocked_no_ack", saw, 0);
        check("blocked_free", bus.free[LOCAL], 0);
`ifdef SWITCH_CTRL_PERF_CNT_EN
        check("block_cnt", bus.block_cnt, 4);
`endif
        bus.sender[EAST] = 1'b0;
        cyc();
        check("release_lat", bus.free[LOCAL], 1);
        wait_ack(10, got, n);
        bus.h[NORTH] = 1'b0;
        if (!got) begin
            check("retry_timeout", 1, 0);
            void'(sb.pop_front());
        end else begin
            check_grant("retry", n, 0);
        end
        cyc();
`ifdef SWITCH_CTRL_PERF_CNT_EN
        check("grant_cnt_a", bus.grant_cnt, 9);
`endif

        // Reset in the middle of S_ROUTE.
        set_hdr(SOUTH, 16'h0022);
        bus.sender[SOUTH] = 1'b1;
        bus.h[SOUTH]      = 1'b1;
        cyc();
        cyc();
        check("pre_rst_state", dut.r_state, S_ROUTE);
        rst        = 1'b1;
        bus.h      = '0;
        bus.sender = '0;
        #1;
        check("mid_rst_free", bus.free, 5'h1F);
        check("mid_rst_tab_in", bus.tab_in_t, 0);
        check("mid_rst_tab_out", bus.tab_out_t, 0);
        cyc();
        check("mid_rst_ack", bus.ack_h, 0);
        check("mid_rst_state", dut.r_state, S_IDLE);
        rst = 1'b0;

        // Round robin with every input requesting.
        set_hdr(EAST,  16'h0011);
        set_hdr(WEST,  16'h0021);
        set_hdr(NORTH, 16'h0001);
        set_hdr(SOUTH, 16'h0012);
        set_hdr(LOCAL, 16'h0010);
        bus.sender = 5'b11110;
        bus.h      = 5'b11111;
        sb.push_back('{src: EAST,  dir: LOCAL});
        sb.push_back('{src: WEST,  dir: EAST});
        sb.push_back('{src: NORTH, dir: WEST});
        sb.push_back('{src: SOUTH, dir: NORTH});
        sb.push_back('{src: LOCAL, dir: SOUTH});
        sb.push_back('{src: EAST,  dir: LOCAL});
        prev = -1;
        for (int c = 1; c <= 60 && sb.size() > 0; c++) begin
            cyc();
            if (bus.ack_h != '0) begin
                check_grant($sformatf("rr_c%0d", c), c, prev < 0 ? 3 : 0);
                if (prev >= 0)
                    check("rr_spacing", c - prev, 4);
                prev = c;
            end
        end
        check("rr_left", sb.size(), 0);
        sb.delete();
        bus.h      = '0;
        bus.sender = '0;
        repeat (6) cyc();
        check("rr_all_free", bus.free, 5'h1F);
`ifdef SWITCH_CTRL_PERF_CNT_EN
        check("grant_cnt_b", bus.grant_cnt, 6);

        // Counter wrap from 0xFFFF.
        force dut.r_grant_cnt = 16'hFFFF;
        #1;
        release dut.r_grant_cnt;
        check("wrap_pre", bus.grant_cnt, 16'hFFFF);
        do_req("wrap", WEST, 16'h0011, LOCAL);
        check("wrap_post", bus.grant_cnt, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
